// File: rtl/dw_reg_array.sv
// Per-row pixel register array feeding the depthwise PE array.
// Each lane register loads, shifts into a reuse FIFO, or takes a neighbour FIFO's head.
module dw_reg_array #(
    parameter int DW     = 8,
    parameter int POY    = 3,
    parameter int STRIDE = 1,
    parameter int FDEPTH = 4,
    parameter int KSIZE  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [POY*DW-1:0]   pix_in,
    input  logic [2*POY-1:0]    reg_array_cmd,
    input  logic                fifo_read,
    output logic [POY*DW-1:0]   pix_out,
    output logic                pix_vld,
    output logic [POY-1:0]      fifo_empty,
    output logic [POY-1:0]      fifo_full,
    output logic                err_ovf,
    output logic                err_udf
);

    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int CW = $clog2(FDEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FDEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FDEPTH);

    typedef enum logic [1:0] {
        CMD_IB = 2'b00,
        CMD_SF = 2'b01,
        CMD_IF = 2'b10,
        CMD_NE = 2'b11
    } cmd_e;

    if (STRIDE < 1 || STRIDE > 2 || STRIDE >= POY) begin : gBadStride
        $error("dw_reg_array: STRIDE must be 1 or 2 and less than POY");
    end
    if (FDEPTH < KSIZE) begin : gBadDepth
        $error("dw_reg_array: FDEPTH must be at least KSIZE");
    end

    logic [DW-1:0] lane_q  [POY];
    logic [DW-1:0] lane_d  [POY];
    logic [DW-1:0] mem_q   [POY][FDEPTH];
    logic [PW-1:0] rdPtr_q [POY];
    logic [PW-1:0] rdPtr_d [POY];
    logic [PW-1:0] wrPtr_q [POY];
    logic [PW-1:0] wrPtr_d [POY];
    logic [CW-1:0] count_q [POY];
    logic [CW-1:0] count_d [POY];
    logic          vld_q, vld_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    cmd_e          laneCmd [POY];
    logic [DW-1:0] head    [POY];
    logic [POY-1:0] pop;
    logic [POY-1:0] wrEn;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < POY; i++) begin
            laneCmd[i]    = cmd_e'(reg_array_cmd[2*i +: 2]);
            head[i]       = mem_q[i][rdPtr_q[i]];
            fifo_empty[i] = (count_q[i] == '0);
            fifo_full[i]  = (count_q[i] == CNT_FULL);
            pix_out[i*DW +: DW] = lane_q[i];
        end
    end

    // Source FIFO heads are sampled before this cycle's pop, so IF with fifo_read sees the old head.
    always_comb begin
        int src;
        vld_d = 1'b0;
        ovf_d = ovf_q;
        udf_d = udf_q;
        src   = 0;
        for (int i = 0; i < POY; i++) begin
            lane_d[i]  = lane_q[i];
            rdPtr_d[i] = rdPtr_q[i];
            wrPtr_d[i] = wrPtr_q[i];
            count_d[i] = count_q[i];
            pop[i]     = fifo_read && !fifo_empty[i];
            wrEn[i]    = (laneCmd[i] == CMD_SF) && (!fifo_full[i] || pop[i]);
            src        = (i + STRIDE) % POY;

            if (fifo_read && fifo_empty[i]) begin
                udf_d = 1'b1;
            end
            if ((laneCmd[i] == CMD_SF) && fifo_full[i] && !pop[i]) begin
                ovf_d = 1'b1;
            end
            if (laneCmd[i] != CMD_NE) begin
                vld_d = 1'b1;
            end

            case (laneCmd[i])
                CMD_IB, CMD_SF: lane_d[i] = pix_in[i*DW +: DW];
                CMD_IF: begin
                    if (i < POY - STRIDE) begin
                        if (fifo_empty[src]) begin
                            lane_d[i] = '0;
                            udf_d     = 1'b1;
                        end else begin
                            lane_d[i] = head[src];
                        end
                    end else begin
                        lane_d[i] = pix_in[i*DW +: DW];
                    end
                end
                default: ;
            endcase

            if (pop[i]) begin
                rdPtr_d[i] = ptrInc(rdPtr_q[i]);
            end
            if (wrEn[i]) begin
                wrPtr_d[i] = ptrInc(wrPtr_q[i]);
            end
            case ({wrEn[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < POY; i++) begin
                lane_q[i]  <= '0;
                rdPtr_q[i] <= '0;
                wrPtr_q[i] <= '0;
                count_q[i] <= '0;
            end
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            for (int i = 0; i < POY; i++) begin
                lane_q[i]  <= lane_d[i];
                rdPtr_q[i] <= rdPtr_d[i];
                wrPtr_q[i] <= wrPtr_d[i];
                count_q[i] <= count_d[i];
            end
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage needs no reset: a zero count hides whatever stale data remains.
    always_ff @(posedge clk) begin
        for (int i = 0; i < POY; i++) begin
            if (wrEn[i]) begin
                mem_q[i][wrPtr_q[i]] <= lane_q[i];
            end
        end
    end

    assign pix_vld = vld_q;
    assign err_ovf = ovf_q;
    assign err_udf = udf_q;

endmodule

// File: tb/tb_dw_reg_array.sv
// Randomised scoreboard bench for dw_reg_array against a queue-based reference model.
module tb_dw_reg_array;

    localparam int DW     = 8;
    localparam int POY    = 3;
    localparam int STRIDE = 1;
    localparam int FDEPTH = 4;
    localparam int KSIZE  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [POY*DW-1:0]   pixIn = '0;
    logic [2*POY-1:0]    cmd = '1;
    logic                fifoRead = 1'b0;
    logic [POY*DW-1:0]   pix_out;
    logic                pix_vld;
    logic [POY-1:0]      fifo_empty;
    logic [POY-1:0]      fifo_full;
    logic                err_ovf;
    logic                err_udf;

    dw_reg_array #(
        .DW(DW), .POY(POY), .STRIDE(STRIDE), .FDEPTH(FDEPTH), .KSIZE(KSIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_in(pixIn),
        .reg_array_cmd(cmd),
        .fifo_read(fifoRead),
        .pix_out(pix_out),
        .pix_vld(pix_vld),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .err_ovf(err_ovf),
        .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [POY*DW-1:0] pixOut;
        logic              vld;
        logic [POY-1:0]    empty;
        logic [POY-1:0]    full;
        logic              ovf;
        logic              udf;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    logic [DW-1:0] mReg  [POY];
    logic [DW-1:0] mFifo [POY][$];
    logic          mOvf;
    logic          mUdf;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic modelReset();
        for (int i = 0; i < POY; i++) begin
            mReg[i] = '0;
            mFifo[i].delete();
        end
        mOvf = 1'b0;
        mUdf = 1'b0;
    endtask

    // Heads are read before any pop; pop precedes push so a full lane with pop+push never overflows.
    task automatic modelStep(input logic [2*POY-1:0] c, input logic [POY*DW-1:0] p, input logic rd);
        logic [DW-1:0] newReg [POY];
        logic [1:0]    lc;
        exp_t          e;
        e.vld = 1'b0;
        for (int i = 0; i < POY; i++) begin
            lc = c[2*i +: 2];
            newReg[i] = mReg[i];
            if (lc != 2'b11) e.vld = 1'b1;
            if (lc == 2'b00 || lc == 2'b01) newReg[i] = p[i*DW +: DW];
            else if (lc == 2'b10) begin
                if (i + STRIDE < POY) begin
                    if (mFifo[i+STRIDE].size() == 0) begin
                        newReg[i] = '0;
                        mUdf = 1'b1;
                    end else begin
                        newReg[i] = mFifo[i+STRIDE][0];
                    end
                end else begin
                    newReg[i] = p[i*DW +: DW];
                end
            end
        end
        for (int i = 0; i < POY; i++) begin
            lc = c[2*i +: 2];
            if (rd) begin
                if (mFifo[i].size() == 0) mUdf = 1'b1;
                else void'(mFifo[i].pop_front());
            end
            if (lc == 2'b01) begin
                if (mFifo[i].size() == FDEPTH) mOvf = 1'b1;
                else mFifo[i].push_back(mReg[i]);
            end
        end
        for (int i = 0; i < POY; i++) begin
            mReg[i] = newReg[i];
            e.pixOut[i*DW +: DW] = mReg[i];
            e.empty[i] = (mFifo[i].size() == 0);
            e.full[i]  = (mFifo[i].size() == FDEPTH);
        end
        e.ovf = mOvf;
        e.udf = mUdf;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2*POY-1:0] c, input logic [POY*DW-1:0] p, input logic rd);
        cmd      = c;
        pixIn    = p;
        fifoRead = rd;
        @(posedge clk);
        modelStep(c, p, rd);
        #1;
    endtask

    // Reset lands mid-cycle, so the outputs must clear before any clock edge arrives.
    task automatic asyncReset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRst pixOut", 32'(pix_out), 32'h0);
        checkOutput("asyncRst vld", 32'(pix_vld), 32'h0);
        checkOutput("asyncRst empty", 32'(fifo_empty), 32'h7);
        checkOutput("asyncRst full", 32'(fifo_full), 32'h0);
        checkOutput("asyncRst ovf", 32'(err_ovf), 32'h0);
        checkOutput("asyncRst udf", 32'(err_udf), 32'h0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pixOut", 32'(pix_out), 32'(e.pixOut));
                checkOutput("pixVld", 32'(pix_vld), 32'(e.vld));
                checkOutput("fifoEmpty", 32'(fifo_empty), 32'(e.empty));
                checkOutput("fifoFull", 32'(fifo_full), 32'(e.full));
                checkOutput("errOvf", 32'(err_ovf), 32'(e.ovf));
                checkOutput("errUdf", 32'(err_udf), 32'(e.udf));
            end
        end
    end

    initial begin : driver
        modelReset();
        #12;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 5; k++) applyStimulus(6'b111111, 24'($urandom), 1'b0);

        applyStimulus(6'b000000, 24'h332211, 1'b0);
        applyStimulus(6'b010101, 24'h665544, 1'b0);
        applyStimulus(6'b001010, 24'h770000, 1'b0);

        asyncReset();
        applyStimulus(6'b000000, 24'hA5B6C7, 1'b0);

        asyncReset();
        for (int k = 1; k <= 5; k++) applyStimulus(6'b111101, 24'(k * 8'h11), 1'b0);

        asyncReset();
        applyStimulus(6'b111111, 24'h0, 1'b1);
        for (int k = 1; k <= 4; k++) applyStimulus(6'b111101, 24'(k * 8'h21), 1'b0);
        applyStimulus(6'b111101, 24'h0000C3, 1'b1);
        applyStimulus(6'b101010, 24'h0000D4, 1'b0);

        for (int k = 0; k < 400; k++) begin
            if (k % 80 == 79) asyncReset();
            applyStimulus(6'($urandom), 24'($urandom), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #1;
        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
